// File: rtl/axi_rr_id_arbiter.sv
// 4-way round-robin arbiter driving the ID/data mux select; grant lands 1 cycle after req, the select stays locked until done.
// Backpressure: addr_valid is held until addr_ready; an optional watchdog aborts a DATA phase that never sees done.
module axi_rr_id_arbiter #(
  parameter logic [1:0]  START_PTR = 2'd0,
  parameter int unsigned WATCHDOG  = 0
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic [3:0] req,
  input  logic       addr_ready,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       addr_valid,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam bit          WD_EN   = (WATCHDOG != 0);
  localparam logic [15:0] WD_LAST = 16'(WATCHDOG - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic        start, finish, expire;
  logic        found;
  logic [1:0]  idx, winner;

  // Rotating priority scan starting at ptr.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      ptr_q     <= START_PTR;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_cnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ADDR;
          start   = 1'b1;
        end
      end
      ADDR: begin
        // done is deliberately ignored here; only the address handshake or a withdrawal moves on.
        if (!req[sel_q]) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else if (addr_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (done) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
          state_d = IDLE;
          finish  = 1'b1;
          expire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d     = sel_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    timeout_d = expire;
    wd_cnt_d  = wd_cnt_q;
    if (start) begin
      sel_d   = winner;
      grant_d = 4'(1) << winner;
      busy_d  = 1'b1;
    end
    if (finish) begin
      grant_d = 4'b0000;
      busy_d  = 1'b0;
      ptr_d   = sel_q + 2'd1;
    end
    if (state_q == ADDR && state_d == DATA) begin
      wd_cnt_d = 16'd0;
    end else if (state_q == DATA && !done) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  assign addr_valid = (state_q == ADDR) & req[sel_q];
  assign grant      = grant_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_axi_rr_id_arbiter.sv
// Bench for axi_rr_id_arbiter: directed scenarios plus a randomized run against an owner/phase reference model.
module tb_axi_rr_id_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [3:0] req = 4'b0;
  logic       addr_ready = 1'b0;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       addr_valid, busy, timeout;

  logic [3:0] req_w = 4'b0;
  logic       ready_w = 1'b0;
  logic       done_w = 1'b0;
  logic [3:0] grant_w;
  logic [1:0] sel_w;
  logic       av_w, busy_w, timeout_w;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 address, 2 data; owner index kept in m_sel.
  int m_phase, m_ptr, m_sel;

  always #5 ACLK = ~ACLK;

  axi_rr_id_arbiter #(.START_PTR(2'd0), .WATCHDOG(0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req(req), .addr_ready(addr_ready), .done(done),
    .grant(grant), .sel(sel), .addr_valid(addr_valid), .busy(busy), .timeout(timeout)
  );

  axi_rr_id_arbiter #(.START_PTR(2'd0), .WATCHDOG(8)) dut_wd (
    .ACLK(ACLK), .ARESETn(ARESETn), .req(req_w), .addr_ready(ready_w), .done(done_w),
    .grant(grant_w), .sel(sel_w), .addr_valid(av_w), .busy(busy_w), .timeout(timeout_w)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic ar, input logic d);
    int best, bestd;
    best  = -1;
    bestd = 5;
    case (m_phase)
      0: begin
        for (int i = 0; i < 4; i++)
          if (r[i] && ((i - m_ptr + 4) % 4) < bestd) begin
            best  = i;
            bestd = (i - m_ptr + 4) % 4;
          end
        if (best >= 0) begin
          m_sel   = best;
          m_phase = 1;
        end
      end
      1: begin
        if (!r[m_sel]) begin
          m_phase = 0;
          m_ptr   = (m_sel + 1) % 4;
        end else if (ar) m_phase = 2;
      end
      default: begin
        if (d) begin
          m_phase = 0;
          m_ptr   = (m_sel + 1) % 4;
        end
      end
    endcase
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    req = 4'b0; addr_ready = 1'b0; done = 1'b0;
    tick();
    checks++;
    if ({grant, sel, addr_valid, busy, timeout} !== 9'b0) begin
      errors++;
      $display("FAIL reset: got grant=%b sel=%0d av=%b busy=%b to=%b expected all zero",
               grant, sel, addr_valid, busy, timeout);
    end
    checks++;
    if ({grant_w, sel_w, av_w, busy_w, timeout_w} !== 9'b0) begin
      errors++;
      $display("FAIL reset_wd: got grant=%b sel=%0d busy=%b to=%b expected all zero",
               grant_w, sel_w, busy_w, timeout_w);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic test_basic();
    req = 4'b1010;
    tick();
    checks++;
    if ({sel, grant, addr_valid, busy} !== {2'd1, 4'b0010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL basic_grant: got sel=%0d grant=%b av=%b busy=%b expected sel=1 grant=0010 av=1 busy=1",
               sel, grant, addr_valid, busy);
    end
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
    checks++;
    if ({sel, grant, addr_valid, busy} !== {2'd1, 4'b0010, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_data: got sel=%0d grant=%b av=%b busy=%b expected sel=1 grant=0010 av=0 busy=1",
               sel, grant, addr_valid, busy);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if ({grant, busy, sel} !== {4'b0000, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL basic_done: got grant=%b busy=%b sel=%0d expected grant=0000 busy=0 sel=1", grant, busy, sel);
    end
    tick();
    checks++;
    if ({sel, grant} !== {2'd3, 4'b1000}) begin
      errors++;
      $display("FAIL basic_next: got sel=%0d grant=%b expected sel=3 grant=1000", sel, grant);
    end
    addr_ready = 1'b1; tick(); addr_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    req = 4'b0;
  endtask

  task automatic test_rr_order();
    logic [1:0] exp_sel;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_sel = 2'(t % 4);
      tick();
      checks++;
      if ({sel, grant} !== {exp_sel, 4'(1 << exp_sel)}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got sel=%0d grant=%b expected sel=%0d", t, sel, grant, exp_sel);
      end
      addr_ready = 1'b1; tick(); addr_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({sel, busy} !== {exp_sel, 1'b1}) begin
        errors++;
        $display("FAIL rr_hold[%0d]: got sel=%0d busy=%b expected sel=%0d busy=1", t, sel, busy, exp_sel);
      end
      done = 1'b1; tick(); done = 1'b0;
      checks++;
      if ({sel, grant, busy} !== {exp_sel, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL rr_done[%0d]: got sel=%0d grant=%b busy=%b expected sel=%0d idle",
                 t, sel, grant, busy, exp_sel);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_data_ignore();
    req = 4'b0100;
    tick();
    addr_ready = 1'b1; tick(); addr_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      checks++;
      if ({sel, grant, addr_valid} !== {2'd2, 4'b0100, 1'b0}) begin
        errors++;
        $display("FAIL data_ignore[%0d]: got sel=%0d grant=%b av=%b expected sel=2 grant=0100 av=0",
                 c, sel, grant, addr_valid);
      end
    end
    req = 4'b0001;
    done = 1'b1; tick(); done = 1'b0;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL data_bubble: got grant=%b expected 0000", grant);
    end
    tick();
    checks++;
    if ({sel, grant} !== {2'd0, 4'b0001}) begin
      errors++;
      $display("FAIL data_next: got sel=%0d grant=%b expected sel=0 grant=0001", sel, grant);
    end
    addr_ready = 1'b1; tick(); addr_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    req = 4'b0;
  endtask

  task automatic test_withdraw();
    req = 4'b0010;
    tick();
    checks++;
    if ({sel, grant, addr_valid} !== {2'd1, 4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL wd_grant: got sel=%0d grant=%b av=%b expected sel=1 grant=0010 av=1", sel, grant, addr_valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({grant, busy} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL withdraw: got grant=%b busy=%b expected grant=0000 busy=0", grant, busy);
    end
    req = 4'b0011;
    tick();
    checks++;
    if ({sel, grant} !== {2'd0, 4'b0001}) begin
      errors++;
      $display("FAIL withdraw_wrap: got sel=%0d grant=%b expected sel=0 grant=0001", sel, grant);
    end
    req = 4'b0000; tick();
    req = 4'b0010; tick();
    addr_ready = 1'b1; done = 1'b1;
    tick();
    addr_ready = 1'b0;
    checks++;
    if ({sel, grant, addr_valid, busy} !== {2'd1, 4'b0010, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL addr_done_ignored: got sel=%0d grant=%b av=%b busy=%b expected sel=1 grant=0010 av=0 busy=1",
               sel, grant, addr_valid, busy);
    end
    tick();
    done = 1'b0;
    req = 4'b0;
    checks++;
    if ({grant, busy} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL addr_done_complete: got grant=%b busy=%b expected idle", grant, busy);
    end
  endtask

  task automatic test_watchdog();
    int pulses;
    req_w = 4'b0001; tick();
    ready_w = 1'b1; tick(); ready_w = 1'b0;
    req_w = 4'b0000;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (timeout_w) pulses++;
    end
    checks++;
    if ({busy_w, pulses} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL wdog_early: got busy=%b pulses=%0d expected busy=1 pulses=0", busy_w, pulses);
    end
    tick();
    checks++;
    if ({timeout_w, busy_w, grant_w} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL wdog_expire: got to=%b busy=%b grant=%b expected to=1 busy=0 grant=0000",
               timeout_w, busy_w, grant_w);
    end
    tick();
    checks++;
    if (timeout_w !== 1'b0) begin
      errors++;
      $display("FAIL wdog_pulse_width: got to=%b expected 0", timeout_w);
    end
    req_w = 4'b0010; tick();
    checks++;
    if ({sel_w, grant_w} !== {2'd1, 4'b0010}) begin
      errors++;
      $display("FAIL wdog_ptr: got sel=%0d grant=%b expected sel=1 grant=0010", sel_w, grant_w);
    end
    ready_w = 1'b1; tick(); ready_w = 1'b0;
    req_w = 4'b0000;
    for (int k = 0; k < 7; k++) tick();
    done_w = 1'b1; tick(); done_w = 1'b0;
    checks++;
    if ({timeout_w, busy_w} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wdog_done_wins: got to=%b busy=%b expected to=0 busy=0", timeout_w, busy_w);
    end
    tick();
    checks++;
    if (timeout_w !== 1'b0) begin
      errors++;
      $display("FAIL wdog_no_late_pulse: got to=%b expected 0", timeout_w);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0100; tick();
    addr_ready = 1'b1; tick(); addr_ready = 1'b0;
    req = 4'b0000;
    checks++;
    if ({sel, busy} !== {2'd2, 1'b1}) begin
      errors++;
      $display("FAIL areset_setup: got sel=%0d busy=%b expected sel=2 busy=1", sel, busy);
    end
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if ({grant, busy, sel} !== {4'b0000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL areset_immediate: got grant=%b busy=%b sel=%0d expected all zero", grant, busy, sel);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    req = 4'b0100;
    tick();
    checks++;
    if ({sel, grant, addr_valid} !== {2'd2, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL areset_regrant: got sel=%0d grant=%b av=%b expected sel=2 grant=0100 av=1",
               sel, grant, addr_valid);
    end
    req = 4'b0000; tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_grant;
    logic       exp_av;
    ARESETn = 1'b0;
    req = 4'b0; addr_ready = 1'b0; done = 1'b0;
    tick();
    @(negedge ACLK);
    ARESETn = 1'b1;
    m_phase = 0; m_ptr = 0; m_sel = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      addr_ready = ($urandom_range(0, 2) == 0);
      done       = ($urandom_range(0, 3) == 0);
      #1;
      exp_av = (m_phase == 1) && req[m_sel];
      checks++;
      if (addr_valid !== exp_av) begin
        errors++;
        $display("FAIL rand_av[%0d]: got %b expected %b", c, addr_valid, exp_av);
      end
      model_edge(req, addr_ready, done);
      tick();
      exp_grant = (m_phase != 0) ? 4'(1 << m_sel) : 4'b0000;
      checks++;
      if ({grant, sel, busy, timeout} !== {exp_grant, 2'(m_sel), (m_phase != 0), 1'b0}) begin
        errors++;
        $display("FAIL rand_state[%0d]: got grant=%b sel=%0d busy=%b to=%b expected grant=%b sel=%0d busy=%b to=0",
                 c, grant, sel, busy, timeout, exp_grant, m_sel, (m_phase != 0));
      end
    end
    req = 4'b0; addr_ready = 1'b0; done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr_order();
    test_data_ignore();
    test_withdraw();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rr_id_arbiter.md
Name: axi_rr_id_arbiter

Overview:
- 4-requester round-robin arbiter driving the 2-bit select of the downstream 4-input ID/data mux.
- Picks one requester and forwards its address-valid.
- Holds the select locked from grant until the burst's last-beat handshake, so mux output cannot switch mid-transaction.
- Single outstanding transaction; sits between the master-side request lines and the ID/data mux feeding the slave side.

Parameters:
- START_PTR, 2'd0, requester index with highest priority after reset.
- WATCHDOG, 0, max cycles allowed in DATA state; 0 disables the timeout.

Ports:
- ACLK  input  1  clock, all state on rising edge
- ARESETn  input  1  asynchronous active-low reset
- req  input  4  per-requester request (address valid), bit i = requester i
- addr_ready  input  1  slave accepts the forwarded address this cycle
- done  input  1  last data beat handshake of current burst (LAST & VALID & READY)
- grant  output  4  one-hot grant to the winning requester
- sel  output  2  select to the downstream mux (index of current/last winner)
- addr_valid  output  1  forwarded address valid to slave
- busy  output  1  high in ADDR or DATA
- timeout  output  1  single-cycle pulse when the watchdog aborts a transaction

Behaviour:
- States: IDLE, ADDR, DATA. All outputs registered except addr_valid, which is combinational: (state==ADDR) & req[sel].
- Reset (async, ARESETn=0):
  - state=IDLE, ptr=START_PTR, sel=2'd0, grant=4'b0000, busy=0, timeout=0, watchdog counter=0.
  - Reset asserted mid-transaction aborts immediately; no completion pulse.
- IDLE:
  - If any req bit is set, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - On the next edge: sel<=winner, grant<=onehot(winner), busy<=1, state<=ADDR.
  - Latency from req to grant/addr_valid is 1 cycle.
  - With no req, sel holds the last winner, so the mux output is stable.
  - grant=0.
- ADDR:
  - addr_valid=req[sel].
  - If addr_valid & addr_ready: state<=DATA.
  - If req[sel] deasserts before the handshake (withdrawal): state<=IDLE, grant<=0, busy<=0, ptr<=sel+1.
  - done is ignored in ADDR, including when it coincides with addr_ready.
- DATA:
  - grant and sel held; addr_valid=0.
  - Any req activity from any requester is ignored.
  - On done: state<=IDLE, grant<=0, busy<=0, ptr<=sel+1 (wraps 3->0).
  - A new request is arbitrated no earlier than the cycle after the return to IDLE, i.e. a 1-cycle bubble.
- Watchdog (WATCHDOG>0):
  - 16-bit counter cleared on entering DATA; increments each DATA cycle without done.
  - When the counter reaches WATCHDOG-1 without done: state<=IDLE, grant<=0, busy<=0, ptr<=sel+1, timeout pulses high for one cycle.
  - done in the same cycle as expiry counts as normal completion; no timeout.
- Pointer rules:
  - ptr changes only on completion, withdrawal or timeout; never on grant.
  - Guarantees each requester waits at most 3 transactions.
- Invariants:
  - grant is onehot0 at all times.
  - grant!=0 iff busy.
  - sel never changes while busy=1.
  - done/addr_ready in IDLE have no effect.

Test Plan:
- Reset with START_PTR=0, then req=4'b1010 -> next cycle sel=1, grant=4'b0010, addr_valid=1; addr_ready pulse -> DATA; done -> IDLE, ptr=2; req still 4'b1010 -> sel=3, grant=4'b1000.
- req=4'b1111 held for 5 transactions, each completed with done -> grant order 0,1,2,3,0; sel constant from grant through done every time.
- In DATA with sel=2, toggle req=4'b0001 for 10 cycles -> sel and grant=4'b0100 unchanged, addr_valid=0; done -> requester 0 granted after 1 idle cycle.
- ADDR with sel=1, drop req[1] before addr_ready -> IDLE next cycle, grant=0, busy=0; a later req=4'b0011 grants requester 0 (ptr=2 wraps to 0).
- WATCHDOG=8, enter DATA, never assert done -> after 8 DATA cycles timeout pulses exactly once, busy=0, grant=0; repeat with done in cycle 8 -> no timeout.
- Assert ARESETn=0 asynchronously mid-DATA (between clock edges) -> grant=0, busy=0, sel=0 immediately; after release, req=4'b0100 -> sel=2 in one cycle.
